// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the ALU-side bus and the result bus of alu_arbiter.
// slave is the arbiter's view; master is the view of the clients and ALU driving it.
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 6
);
  logic             req0;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [OPW-1:0]   op0;
  logic             gnt0;
  logic             done0;

  logic             req1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic [OPW-1:0]   op1;
  logic             gnt1;
  logic             done1;

  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr;
  logic             alu_ng;

  logic [WIDTH-1:0] res;
  logic             res_zr;
  logic             res_ng;
  logic             busy;

  modport slave (
    input  req0, x0, y0, op0, req1, x1, y1, op1, alu_out, alu_zr, alu_ng,
    output gnt0, done0, gnt1, done1, alu_x, alu_y, alu_op, res, res_zr, res_ng, busy
  );

  modport master (
    output req0, x0, y0, op0, req1, x1, y1, op1, alu_out, alu_zr, alu_ng,
    input  gnt0, done0, gnt1, done1, alu_x, alu_y, alu_op, res, res_zr, res_ng, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// registers the winner's operands, waits ALU_LAT cycles, captures and returns the result.
module alu_arbiter #(
  parameter int             WIDTH   = 16,
  parameter int             OPW     = 6,
  parameter int             ALU_LAT = 1,
  parameter logic [OPW-1:0] IDLE_OP = 6'b010101
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_x_q, alu_x_d;
  logic [WIDTH-1:0] alu_y_q, alu_y_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_zr_q, res_zr_d;
  logic             res_ng_q, res_ng_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             win;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    alu_x_d  = alu_x_q;
    alu_y_d  = alu_y_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    res_zr_d = res_zr_q;
    res_ng_d = res_ng_q;
    gnt_d    = '0;
    done_d   = '0;
    // ptr_q names the favoured requester, consulted only on a tie
    win      = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          ptr_d        = ~win;
          owner_d      = win;
          cnt_d        = CNT_INIT;
          alu_x_d      = win ? bus.x1  : bus.x0;
          alu_y_d      = win ? bus.y1  : bus.y0;
          alu_op_d     = win ? bus.op1 : bus.op0;
          gnt_d[win]   = 1'b1;
          state_d      = S_EXEC;
        end else begin
          alu_op_d = IDLE_OP;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          res_d           = bus.alu_out;
          res_zr_d        = bus.alu_zr;
          res_ng_d        = bus.alu_ng;
          done_d[owner_q] = 1'b1;
          state_d         = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      alu_op_q <= IDLE_OP;
      res_q    <= '0;
      res_zr_q <= 1'b0;
      res_ng_q <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      alu_x_q  <= alu_x_d;
      alu_y_q  <= alu_y_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      res_zr_q <= res_zr_d;
      res_ng_q <= res_ng_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.gnt0   = gnt_q[0];
  assign bus.gnt1   = gnt_q[1];
  assign bus.done0  = done_q[0];
  assign bus.done1  = done_q[1];
  assign bus.alu_x  = alu_x_q;
  assign bus.alu_y  = alu_y_q;
  assign bus.alu_op = alu_op_q;
  assign bus.res    = res_q;
  assign bus.res_zr = res_zr_q;
  assign bus.res_ng = res_ng_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule
